// File: rtl/keypad_scanner_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// keypad_scanner_fifo
//
// Matrix-keypad scanner with sweep-level debounce and a small key-code FIFO.
// One row is driven at a time for SCAN_DIV cycles. The synchronized column
// lines are sampled on the last cycle of each row period. A full sweep that
// shows exactly one closed switch resolves to code = row*N_COLUMNAS + col.
// A four-state FSM debounces press and release over whole sweeps and pushes
// each accepted code into a FIFO. The FIFO is drained through a valid/ready
// handshake.
//
// Optional feature (macro KEY_REPEAT_EN): while a key stays held, the code is
// pushed again every REPEAT_SWEEPS sweeps. When the macro is undefined, each
// debounced press produces exactly one push.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   columna     in   column sense lines, active-high, asynchronous
//   fila        out  row drive, one-hot, active-high
//   key_code    out  registered FIFO head code
//   key_valid   out  FIFO not empty
//   key_ready   in   consumer takes the head when key_valid & key_ready
//   fifo_count  out  number of entries held (0..FIFO_DEPTH)
//   overflow    out  sticky: a code was dropped because the FIFO was full
//   sweep_done  out  one-cycle pulse after the last row sample of a sweep
// -----------------------------------------------------------------------------
module keypad_scanner_fifo #(
   parameter int N_FILAS       = 4,
   parameter int N_COLUMNAS    = 4,
   parameter int SCAN_DIV      = 1000,
   parameter int DEBOUNCE_CNT  = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int REPEAT_SWEEPS = 32,
   localparam int CODE_W       = $clog2(N_FILAS*N_COLUMNAS),
   localparam int CNT_W        = $clog2(FIFO_DEPTH)+1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_COLUMNAS-1:0] columna,
   output logic [N_FILAS-1:0]    fila,
   output logic [CODE_W-1:0]     key_code,
   output logic                  key_valid,
   input  logic                  key_ready,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow,
   output logic                  sweep_done
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int ROW_W = $clog2(N_FILAS);
   localparam int COL_W = $clog2(N_COLUMNAS);
   localparam int DEB_W = $clog2(DEBOUNCE_CNT+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_SWEEPS+1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEB_PRESS,
      S_HELD,
      S_DEB_REL
   } state_t;

   // ---------------------------------------------------------------- scanning
   logic [N_COLUMNAS-1:0] r_col_meta, r_col_sync;
   logic [DIV_W-1:0]      r_div;
   logic [ROW_W-1:0]      r_row;
   logic [N_FILAS-1:0]    r_fila;
   logic                  r_acc_any, r_acc_multi;
   logic [CODE_W-1:0]     r_acc_code;
   logic                  r_res_key;
   logic [CODE_W-1:0]     r_res_code;
   logic                  r_sweep_done;

   logic                  w_sample, w_last_row;
   logic                  w_col_any, w_col_multi;
   logic [COL_W-1:0]      w_col_idx;
   logic [CODE_W-1:0]     w_row_code;
   logic                  w_m_any, w_m_multi;
   logic [CODE_W-1:0]     w_m_code;

   assign w_sample   = (r_div == DIV_W'(SCAN_DIV-1));
   assign w_last_row = (r_row == ROW_W'(N_FILAS-1));

   // Classify the current row sample: no bit, one bit (with its index), or more.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_col_any   = 1'b0;
      w_col_multi = 1'b0;
      w_col_idx   = '0;
      for (int c = 0; c < N_COLUMNAS; c++) begin
         if (r_col_sync[c]) begin
            if (w_col_any) w_col_multi = 1'b1;
            w_col_any = 1'b1;
            w_col_idx = COL_W'(c);
         end
      end
   end

   assign w_row_code = CODE_W'(r_row) * CODE_W'(N_COLUMNAS) + CODE_W'(w_col_idx);

   // Merge this row into the sweep accumulator. Two hits in different rows
   // (multi-key or ghosting) make the whole sweep ambiguous.
   assign w_m_any   = r_acc_any | w_col_any;
   assign w_m_multi = r_acc_multi | w_col_multi | (r_acc_any & w_col_any);
   assign w_m_code  = (w_col_any && !r_acc_any) ? w_row_code : r_acc_code;

   // NOTE: clocked state uses non-blocking assignments so every register sees
   // the pre-edge value of every other register, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col_meta   <= '0;
         r_col_sync   <= '0;
         r_div        <= '0;
         r_row        <= '0;
         r_fila       <= N_FILAS'(1);
         r_acc_any    <= 1'b0;
         r_acc_multi  <= 1'b0;
         r_acc_code   <= '0;
         r_res_key    <= 1'b0;
         r_res_code   <= '0;
         r_sweep_done <= 1'b0;
      end else begin
         r_col_meta   <= columna;
         r_col_sync   <= r_col_meta;
         r_sweep_done <= 1'b0;
         if (w_sample) begin
            r_div  <= '0;
            r_fila <= {r_fila[N_FILAS-2:0], r_fila[N_FILAS-1]};
            if (w_last_row) begin
               r_row        <= '0;
               r_res_key    <= w_m_any & ~w_m_multi;
               r_res_code   <= w_m_code;
               r_sweep_done <= 1'b1;
               r_acc_any    <= 1'b0;
               r_acc_multi  <= 1'b0;
               r_acc_code   <= '0;
            end else begin
               r_row       <= r_row + ROW_W'(1);
               r_acc_any   <= w_m_any;
               r_acc_multi <= w_m_multi;
               r_acc_code  <= w_m_code;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------- debounce
   state_t            r_state, w_state_nxt;
   logic [CODE_W-1:0] r_cand, w_cand_nxt;
   logic [DEB_W-1:0]  r_deb, w_deb_nxt;
   logic              w_match;
   logic              w_push;
   logic [CODE_W-1:0] w_push_code;
`ifdef KEY_REPEAT_EN
   logic [REP_W-1:0]  r_rep, w_rep_nxt;
`endif

   assign w_match = r_res_key && (r_res_code == r_cand);

   // The FSM only moves on the sweep_done cycle, when the sweep result is fresh.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_deb_nxt   = r_deb;
      w_push      = 1'b0;
`ifdef KEY_REPEAT_EN
      w_rep_nxt   = r_rep;
`endif
      if (r_sweep_done) begin
         case (r_state)
            S_IDLE: begin
               if (r_res_key) begin
                  w_cand_nxt = r_res_code;
                  if (DEBOUNCE_CNT == 1) begin
                     w_push      = 1'b1;
                     w_state_nxt = S_HELD;
                     w_deb_nxt   = '0;
                  end else begin
                     w_state_nxt = S_DEB_PRESS;
                     w_deb_nxt   = DEB_W'(1);
                  end
               end
            end
            S_DEB_PRESS: begin
               if (!r_res_key) begin
                  w_state_nxt = S_IDLE;
                  w_deb_nxt   = '0;
               end else if (w_match) begin
                  if (r_deb == DEB_W'(DEBOUNCE_CNT-1)) begin
                     w_push      = 1'b1;
                     w_state_nxt = S_HELD;
                     w_deb_nxt   = '0;
                  end else begin
                     w_deb_nxt = r_deb + DEB_W'(1);
                  end
               end else begin
                  w_cand_nxt = r_res_code;
                  w_deb_nxt  = DEB_W'(1);
               end
            end
            S_HELD: begin
               if (!w_match) begin
                  w_state_nxt = (DEBOUNCE_CNT == 1) ? S_IDLE : S_DEB_REL;
                  w_deb_nxt   = (DEBOUNCE_CNT == 1) ? '0 : DEB_W'(1);
               end
`ifdef KEY_REPEAT_EN
               else if (r_rep == REP_W'(REPEAT_SWEEPS-1)) begin
                  w_push    = 1'b1;
                  w_rep_nxt = '0;
               end else begin
                  w_rep_nxt = r_rep + REP_W'(1);
               end
`endif
            end
            S_DEB_REL: begin
               // A returning candidate is the same press bouncing: no new push.
               if (w_match) begin
                  w_state_nxt = S_HELD;
                  w_deb_nxt   = '0;
               end else if (r_deb == DEB_W'(DEBOUNCE_CNT-1)) begin
                  w_state_nxt = S_IDLE;
                  w_deb_nxt   = '0;
               end else begin
                  w_deb_nxt = r_deb + DEB_W'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
`ifdef KEY_REPEAT_EN
         if (r_state != S_HELD && w_state_nxt == S_HELD) w_rep_nxt = '0;
`endif
      end
   end

   assign w_push_code = w_cand_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cand  <= '0;
         r_deb   <= '0;
`ifdef KEY_REPEAT_EN
         r_rep   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_deb   <= w_deb_nxt;
`ifdef KEY_REPEAT_EN
         r_rep   <= w_rep_nxt;
`endif
      end
   end

   // -------------------------------------------------------------------- FIFO
   logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CODE_W-1:0] r_head;
   logic              r_overflow;
   logic              w_full, w_pop, w_push_ok;
   logic [PTR_W-1:0]  w_rd_inc;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop     = (r_count != '0) && key_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_rd_inc  = r_rd_ptr + PTR_W'(1);

   // NOTE: storage has no reset; nothing reads a slot before it is written, and
   // the visible head is a separately reset register.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= w_push_code;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= w_rd_inc;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // The head comes straight from the push when the FIFO is (or is about
         // to be) empty; otherwise it advances to the next stored entry on pop.
         if (w_push_ok && (r_count == '0 || (r_count == CNT_W'(1) && w_pop))) begin
            r_head <= w_push_code;
         end else if (w_pop && r_count > CNT_W'(1)) begin
            r_head <= r_mem[w_rd_inc];
         end
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign fila       = r_fila;
   assign key_code   = r_head;
   assign key_valid  = (r_count != '0);
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
   assign sweep_done = r_sweep_done;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_keypad_scanner_fifo
//
// Directed bench for keypad_scanner_fifo with a 4x4 keypad, SCAN_DIV=4,
// DEBOUNCE_CNT=2, FIFO_DEPTH=4 (one sweep = 16 cycles). A keypad model turns
// a pressed-key mask and the row drive into column levels. Expected key codes
// are queued when a press is issued; a monitor pops and compares them whenever
// the DUT hands over a code (key_valid & key_ready).
// -----------------------------------------------------------------------------
module tb_keypad_scanner_fifo;

   localparam int NF = 4;
   localparam int NC = 4;
   localparam int SD = 4;
   localparam int DC = 2;
   localparam int FD = 4;
   localparam int RS = 3;
   localparam int CW = 4;
   localparam int FCW = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NC-1:0]  columna;
   logic [NF-1:0]  fila;
   logic [CW-1:0]  key_code;
   logic           key_valid;
   logic           key_ready;
   logic [FCW-1:0] fifo_count;
   logic           overflow;
   logic           sweep_done;

   logic [NF*NC-1:0] keys;
   int               n_checks = 0;
   int               n_errors = 0;
   int               sb[$];
   int               exp_code;

   keypad_scanner_fifo #(
      .N_FILAS(NF), .N_COLUMNAS(NC), .SCAN_DIV(SD), .DEBOUNCE_CNT(DC),
      .FIFO_DEPTH(FD), .REPEAT_SWEEPS(RS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .columna(columna), .fila(fila),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .fifo_count(fifo_count), .overflow(overflow), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   // Keypad: a closed switch connects its driven row to its column.
   always_comb begin
      columna = '0;
      for (int r = 0; r < NF; r++)
         for (int c = 0; c < NC; c++)
            if (fila[r] && keys[r*NC+c]) columna[c] = 1'b1;
   end

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: a handover happens on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && key_valid && key_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_unexpected: got code %0d, expected no entry", key_code);
         end else begin
            exp_code = sb.pop_front();
            check("pop_code", int'(key_code), exp_code);
         end
      end
   end

   function automatic logic [NF*NC-1:0] mask(input int code);
      logic [NF*NC-1:0] m;
      m = '0;
      m[code] = 1'b1;
      return m;
   endfunction

   // Returns #1 after the edge that raised sweep_done.
   task automatic wait_sweep();
      int t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!sweep_done && t < 40);
      if (!sweep_done) begin
         n_checks++;
         n_errors++;
         $display("FAIL sweep_timeout: got no sweep_done in %0d cycles, expected one", t);
      end
   endtask

   task automatic hold(input logic [NF*NC-1:0] k, input int n);
      keys = k;
      repeat (n) wait_sweep();
   endtask

   task automatic tap(input int code);
      hold(mask(code), 2);
      hold('0, 2);
   endtask

   task automatic drain();
      int t = 0;
      key_ready = 1'b1;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (key_valid && t < 50);
      key_ready = 1'b0;
      check("drain_left_in_queue", sb.size(), 0);
      check("drain_fifo_count", int'(fifo_count), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_fila"}, int'(fila), 1);
      check({tag, "_key_valid"}, int'(key_valid), 0);
      check({tag, "_key_code"}, int'(key_code), 0);
      check({tag, "_fifo_count"}, int'(fifo_count), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
      check({tag, "_sweep_done"}, int'(sweep_done), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      keys      = '0;
      key_ready = 1'b0;

      // Reset and row scanning with no key.
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;
      for (int k = 0; k < 36; k++) begin
         check("scan_fila", int'(fila), 1 << ((k / SD) % NF));
         check("scan_sweep_done", int'(sweep_done), (k % (SD*NF) == 0 && k != 0) ? 1 : 0);
         check("scan_key_valid", int'(key_valid), 0);
         @(posedge clk);
         #1;
      end
      wait_sweep();

      // Key 6 (row 1, col 2) held 3 sweeps: exactly one push.
      sb.push_back(6);
      hold(mask(6), 3);
      check("press6_count", int'(fifo_count), 1);
      check("press6_valid", int'(key_valid), 1);
      check("press6_code", int'(key_code), 6);
      hold('0, 3);
      check("release6_count", int'(fifo_count), 1);
      drain();

      // One-sweep glitch is rejected.
      hold(mask(6), 1);
      hold('0, 2);
      check("glitch_count", int'(fifo_count), 0);
      check("glitch_valid", int'(key_valid), 0);

      // Five taps into a 4-deep FIFO: the fifth is dropped.
      foreach (sb[i]) sb.delete(i);
      sb.push_back(0);
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(3);
      tap(0);
      tap(1);
      tap(2);
      tap(3);
      check("fill_no_ovf_yet", int'(overflow), 0);
      tap(5);
      check("ovf_count", int'(fifo_count), 4);
      check("ovf_flag", int'(overflow), 1);
      check("ovf_head", int'(key_code), 0);
      drain();
      check("ovf_sticky", int'(overflow), 1);
      check("ovf_valid_low", int'(key_valid), 0);

      // Two keys in different rows, then key 15.
      hold(mask(1) | mask(9), 3);
      check("multikey_count", int'(fifo_count), 0);
      hold('0, 2);
      sb.push_back(15);
      tap(15);
      check("key15_code", int'(key_code), 15);
      check("key15_count", int'(fifo_count), 1);
      drain();

      // Reset in the middle of a sweep with a buffered code.
      sb.push_back(4);
      hold(mask(4), 2);
      hold('0, 1);
      check("pre_reset_count", int'(fifo_count), 1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      check_reset_state("midreset");
      rst_n = 1'b1;
      wait_sweep();

      // Push coinciding with a pop while full.
      sb.push_back(7);
      sb.push_back(8);
      sb.push_back(9);
      sb.push_back(10);
      sb.push_back(11);
      tap(7);
      tap(8);
      tap(9);
      tap(10);
      check("full_count", int'(fifo_count), 4);
      hold(mask(11), 2);
      key_ready = 1'b1;
      @(posedge clk);
      #1;
      key_ready = 1'b0;
      check("pushpop_count", int'(fifo_count), 4);
      check("pushpop_overflow", int'(overflow), 0);
      check("pushpop_head", int'(key_code), 8);
      hold('0, 2);
      drain();

`ifdef KEY_REPEAT_EN
      // Key 6 held 10 sweeps: pushes after sweeps 2, 5 and 8.
      sb.push_back(6);
      sb.push_back(6);
      sb.push_back(6);
      hold(mask(6), 10);
      hold('0, 2);
      check("repeat_count", int'(fifo_count), 3);
      check("repeat_overflow", int'(overflow), 0);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/keypad_scanner_fifo.md
Name: keypad_scanner_fifo

Overview:
- Parametrised matrix-keypad scanner for the board's keypad-entry path.
- Drives one row at a time and samples the column inputs.
- Debounces the key found over whole sweeps and resolves it to a linear key code.
- Buffers accepted codes in a small FIFO read through a valid/ready handshake, so downstream logic (display, password check) can consume keys at its own pace.

Parameters:
- N_FILAS, 4: number of keypad rows driven (≥2).
- N_COLUMNAS, 4: number of keypad columns sampled (≥2).
- SCAN_DIV, 1000: clock cycles each row is driven (≥3).
- DEBOUNCE_CNT, 4: consecutive identical sweeps required to accept a press or release (≥1).
- FIFO_DEPTH, 4: key-code buffer entries (power of two, ≥2).
- REPEAT_SWEEPS, 32: sweeps between auto-repeat pushes (used only with the optional feature).
- CODE_W, $clog2(N_FILAS*N_COLUMNAS): key-code width (derived localparam).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- columna  in  N_COLUMNAS  column sense lines, active-high, asynchronous.
- fila  out  N_FILAS  row drive, one-hot, active-high.
- key_code  out  CODE_W  FIFO head code = row_idx*N_COLUMNAS + col_idx.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts head when key_valid & key_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky: a code was dropped because the FIFO was full.
- sweep_done  out  1  one-cycle pulse at the end of each full sweep.

Behaviour:
- Single clock domain; rst_n is synchronous, active-low, sampled on rising clk.
- Reset values:
  - fila = one-hot row 0.
  - row counter = 0, divider = 0.
  - FIFO empty; key_valid = 0, key_code = 0, fifo_count = 0.
  - overflow = 0, sweep_done = 0.
  - FSM = IDLE; debounce counter = 0.
- A reset asserted mid-sweep or mid-debounce discards all state, including buffered codes.
- columna passes through a 2-FF synchronizer. The synchronized value is sampled on the last divider cycle (SCAN_DIV-1) of each row period.
- Row scanning:
  - The divider counts 0..SCAN_DIV-1.
  - On wrap, fila rotates to the next row; row N_FILAS-1 wraps to row 0.
  - One sweep = N_FILAS*SCAN_DIV cycles.
  - sweep_done pulses in the cycle after the last row's sample.
- Sweep result:
  - No bit set → NONE.
  - Exactly one bit set in the whole sweep → KEY(code).
  - More than one bit set (multi-key or ghosting) → NONE.
- FSM, evaluated once per sweep:
  - IDLE: KEY(c) → DEB_PRESS, candidate = c, cnt = 1. NONE → stay.
  - DEB_PRESS: same c → cnt+1; when cnt reaches DEBOUNCE_CNT, push c and go to HELD. Different KEY → restart with the new candidate, cnt = 1. NONE → IDLE.
  - HELD: non-candidate result → DEB_REL, cnt = 1. Candidate → stay.
  - DEB_REL: non-candidate → cnt+1; when cnt reaches DEBOUNCE_CNT → IDLE. Candidate returns → HELD, with no new push.
  - DEBOUNCE_CNT = 1: push on the first sweep showing the key.
- FIFO:
  - Push is one cycle; key_valid rises the cycle after the push.
  - key_code is the registered head and stays stable while key_valid & !key_ready.
  - Pop happens when key_valid & key_ready.
  - Push and pop in the same cycle: count unchanged, both performed, legal when full.
  - Push while full with no pop: code dropped, overflow := 1 until reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is always in 0..FIFO_DEPTH.
  - key_ready while empty has no effect.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In HELD, a sweep counter increments on each sweep showing the candidate.
  - Each time it reaches REPEAT_SWEEPS, the candidate is pushed again and the counter clears.
  - The counter clears on entering HELD.
  - Overflow rules apply to repeat pushes.
- KEY_REPEAT_EN undefined: exactly one push per debounced press. REPEAT_SWEEPS is unused and no repeat logic is synthesized.

Test Plan (bench params: SCAN_DIV=4, DEBOUNCE_CNT=2, FIFO_DEPTH=4, 4x4, sweep = 16 cycles):
- Reset held 3 cycles, then released with columna=0 → fila=0001, then 0010 after 4 cycles, 0100, 1000, back to 0001. sweep_done pulses every 16 cycles. key_valid stays 0.
- columna=0100 only while fila=0010 (key row1/col2), held 3 sweeps, key_ready=0 → one push after the 2nd sweep. key_code=6, key_valid=1, fifo_count=1. No second push while held.
- 1-sweep glitch of key 6, then columna=0 → no push, FSM back to IDLE, fifo_count=0.
- Keys 0,1,2,3,5 pressed and released in turn with key_ready=0 → fifo_count=4, overflow=1. Then key_ready=1 → codes 0,1,2,3 popped in order, key_valid drops, overflow stays 1.
- Two keys in different rows pressed together → no push. Release, then press key 15 → key_code=15.
- Push coinciding with a pop while full → fifo_count stays 4, overflow stays 0. With KEY_REPEAT_EN and REPEAT_SWEEPS=3: key 6 held 10 sweeps → pushes after sweeps 2, 5, 8 = 3 entries.
